plpbot_uart_tx_arbiter: RTL
===========================

# plpbot_uart_tx_arbiter

Round-robin arbiter that shares the single plpbot UART transmitter among four on-chip byte producers (e.g. CPU mailbox, sensor logger, debug trace, motor telemetry). It sits between the requesters and the UART core's send/cts/out_buffer pins. It serialises one byte at a time into the core and returns a one-cycle acknowledge to the requester that was served. A wrapping transmit counter is provided for status readback.

## Interface
- NREQ, 4, number of requesters (fixed at 4; pointer is 2 bits)
- clk  input  1  system clock; all state updates on the falling edge, matching the data bus
- rst  input  1  reset rst, synchronous, active-high
- req  input  4  per-requester request; bit i high = requester i has a byte to send
- req_data  input  32  byte for requester i on bits [8i+7:8i]
- ack  output  4  one-cycle pulse; bit i high = requester i's byte was captured
- cts  input  1  UART core clear-to-send (1 = transmitter idle)
- send  output  1  one-cycle send strobe to the UART core
- tx_byte  output  8  byte presented to the core's out_buffer input
- busy  output  1  high in any state other than IDLE
- grant_id  output  2  index of the requester currently or last served
- tx_count  output  16  number of bytes completed since reset, wraps

## Operation
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE: when cts=1 and req!=0, select the winner as the first set req bit at or after ptr, searching upward modulo 4. Then:
  - tx_byte <= winner's byte; ack[winner] <= 1; grant_id <= winner; go to SEND.
  - If cts=0 or req=0, stay in IDLE.
- SEND: send=1 for exactly this cycle; ack=0; go to WAIT_BUSY.
- WAIT_BUSY: wait for cts=0, then go to WAIT_DONE. If cts is still 1 after 3 cycles in this state, return to SEND and re-strobe. There is no retry limit.
- WAIT_DONE: wait for cts=1, then:
  - ptr <= grant_id+1 (mod 4);
  - tx_count <= tx_count+1 (16-bit, 0xFFFF -> 0x0000);
  - go to IDLE.
- tx_byte is held stable from capture until the next capture, because the core reads out_buffer during the whole frame.
- Requester handshake:
  - Hold req and the data byte stable until ack is seen.
  - ack is never asserted for a requester whose req was low at the IDLE sampling edge.
  - After ack, the requester may drop req or present the next byte with req still high on the following cycle. That next byte competes normally in the next arbitration.
- req changes while not in IDLE are ignored.
- Reset values: state IDLE, ptr 0, ack 0, send 0, tx_byte 0x00, busy 0, grant_id 0, tx_count 0. rst has priority over every transition.
- Reset mid-operation drops the current byte's bookkeeping: no ack, no count. The core's own frame is governed by its own reset.

## Timing
- Arbitration happens at the IDLE falling edge N. ack and tx_byte are valid in cycle N+1, send in cycle N+2.
- The core drops cts one edge after send. WAIT_BUSY is therefore normally exit after 1 cycle.
- Fixed overhead of about 4 clk per byte beyond the UART frame. Back-to-back requests are never starved: each requester waits at most 3 frames.
- With req[0] high in IDLE and cts low, no grant is issued until the edge at which cts is sampled high.

## Configuration
- PLPBOT_UART_ARB_PRIO_EN defined:
  - Requester 0 is high priority and wins whenever req[0] is high at the IDLE sampling edge.
  - ptr is not updated when requester 0 is served.
  - Requesters 1-3 rotate round-robin among themselves.
- Not defined: pure round-robin over all four requesters as described above.

## Test plan
- Reset, then req=4'b0010 with req_data[15:8]=0x5A and cts=1 -> ack=4'b0010 for one cycle, tx_byte=0x5A, then one send pulse; after the modelled cts drops and returns, tx_count=1, grant_id=1, busy=0.
- req=4'b1111 held with distinct bytes 0x10/0x21/0x32/0x43 -> bytes sent in order 0x10,0x21,0x32,0x43,0x10; ack order 0,1,2,3,0 (without PRIO_EN).
- Same stimulus with PLPBOT_UART_ARB_PRIO_EN -> requester 0 is served every arbitration; with req[0] cleared after 2 bytes, the order continues 1,2,3.
- Core model ignores the first send (cts stays 1) -> after 3 WAIT_BUSY cycles send re-pulses; exactly one ack and a tx_count increment of 1.
- Assert rst in WAIT_DONE with a byte in flight -> next edge state IDLE, send=0, ack=0, tx_count unchanged at the reset value 0, tx_byte=0x00.
- Preload tx_count to 0xFFFF via 65535 forced frames (fast core model) and complete one more byte -> tx_count=0x0000.

Source files
------------

// File: rtl/plpbot_uart_tx_arbiter.sv
// Round-robin arbiter feeding one plpbot UART transmitter from four byte producers.
// Define PLPBOT_UART_ARB_PRIO_EN to make requester 0 a fixed high-priority source.
module plpbot_uart_tx_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  input  logic        cts,
  output logic        send,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic [15:0] tx_count
);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitBusy,
    StWaitDone
  } state_t;

  // WAIT_BUSY cycles tolerated with cts still high before re-strobing send.
  localparam logic [1:0] WaitBusyLast = 2'd2;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  ack_q, ack_d;
  logic        send_q, send_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [1:0]  grant_q, grant_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  wb_cnt_q, wb_cnt_d;

  logic [1:0]  win;
  logic [7:0]  win_byte;
  logic        ptr_adv;

  // First set bit of r at or after p, searching upward modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

`ifdef PLPBOT_UART_ARB_PRIO_EN
  // Requester 0 pre-empts the rotation and never moves the pointer.
  assign win     = req[0] ? 2'd0 : rr_pick({req[3:1], 1'b0}, ptr_q);
  assign ptr_adv = (grant_q != 2'd0);
`else
  assign win     = rr_pick(req, ptr_q);
  assign ptr_adv = 1'b1;
`endif

  assign win_byte = req_data[{win, 3'b000} +: 8];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ack_d     = 4'b0000;
    send_d    = 1'b0;
    tx_byte_d = tx_byte_q;
    grant_d   = grant_q;
    count_d   = count_q;
    wb_cnt_d  = wb_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (cts && (req != 4'b0000)) begin
          ack_d     = 4'b0001 << win;
          tx_byte_d = win_byte;
          grant_d   = win;
          state_d   = StSend;
        end
      end
      StSend: begin
        send_d   = 1'b1;
        wb_cnt_d = 2'd0;
        state_d  = StWaitBusy;
      end
      StWaitBusy: begin
        if (!cts) begin
          state_d = StWaitDone;
        end else if (wb_cnt_q == WaitBusyLast) begin
          // Core missed the strobe; try again with no retry limit.
          state_d = StSend;
        end else begin
          wb_cnt_d = wb_cnt_q + 2'd1;
        end
      end
      StWaitDone: begin
        if (cts) begin
          if (ptr_adv) begin
            ptr_d = grant_q + 2'd1;
          end
          count_d = count_q + 16'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State follows the data bus, which changes on the falling edge.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= 2'd0;
      ack_q     <= 4'b0000;
      send_q    <= 1'b0;
      tx_byte_q <= 8'h00;
      grant_q   <= 2'd0;
      count_q   <= 16'h0000;
      wb_cnt_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ack_q     <= ack_d;
      send_q    <= send_d;
      tx_byte_q <= tx_byte_d;
      grant_q   <= grant_d;
      count_q   <= count_d;
      wb_cnt_q  <= wb_cnt_d;
    end
  end

  assign ack      = ack_q;
  assign send     = send_q;
  assign tx_byte  = tx_byte_q;
  assign busy     = (state_q != StIdle);
  assign grant_id = grant_q;
  assign tx_count = count_q;

endmodule
